// File: rtl/sync_ram_pkg.sv
// rtl/sync_ram_pkg.sv - shared constants and request type for the sync RAM port requester
package sync_ram_pkg;

    // Legal RAM read latencies: plain array output, or array plus output register.
    localparam int RAM_LAT_NOREG  = 1;
    localparam int RAM_LAT_OUTREG = 2;

    localparam int REQ_ADDR_WIDTH = 10;
    localparam int REQ_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      wr_en;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/ram_resp_fifo.sv
// rtl/ram_resp_fifo.sv - read response buffer, registered output, no fall-through
//
// Ports:
//   Clk_CI, Rst_RBI    clock, asynchronous active-low reset
//   push, push_data    write one entry
//   pop                remove the head entry
//   pop_data           current head entry (stale when empty)
//   full, empty, count occupancy status
module ram_resp_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RBI,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sync_ram_port_requester.sv
// rtl/sync_ram_port_requester.sv - drives one synchronous RAM port from a request stream, returns reads in order
//
// Ports:
//   Clk_CI, Rst_RBI                         clock, asynchronous active-low reset
//   ReqValid_SI/ReqReady_SO                 request handshake
//   ReqWrEn_SI, ReqAddr_DI, ReqWrData_DI    request payload (1 = write)
//   RespValid_SO/RespReady_SI, RespData_DO  read response stream, request order
//   RamCSel_SO, RamWrEn_SO, RamAddr_DO,
//   RamWrData_DO, RamRdData_DI              RAM port
//   Busy_SO                                 a read is in flight or buffered
module sync_ram_port_requester
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 1,
    parameter int RESP_DEPTH  = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  ReqValid_SI,
    output logic                  ReqReady_SO,
    input  logic                  ReqWrEn_SI,
    input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
    input  logic [DATA_WIDTH-1:0] ReqWrData_DI,
    output logic                  RespValid_SO,
    input  logic                  RespReady_SI,
    output logic [DATA_WIDTH-1:0] RespData_DO,
    output logic                  RamCSel_SO,
    output logic                  RamWrEn_SO,
    output logic [ADDR_WIDTH-1:0] RamAddr_DO,
    output logic [DATA_WIDTH-1:0] RamWrData_DO,
    input  logic [DATA_WIDTH-1:0] RamRdData_DI,
    output logic                  Busy_SO
);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(RESP_DEPTH);

    if (RAM_LATENCY != RAM_LAT_NOREG && RAM_LATENCY != RAM_LAT_OUTREG) begin : g_bad_latency
        $error("sync_ram_port_requester: RAM_LATENCY must be 1 or 2");
    end

    logic [RAM_LATENCY-1:0] pend;
    logic [CNT_W-1:0]       inflight_cnt;
    logic [CNT_W-1:0]       buf_cnt;
    logic [CNT_W:0]         credit_used;
    logic                   rd_accept;
    logic                   push;
    logic                   pop;
    logic                   buf_empty;
    logic                   buf_full;

    // Every read in the pipe already owns a buffer slot, so a push can never
    // find the buffer full; ready therefore depends only on registered counts.
    assign credit_used = {1'b0, inflight_cnt} + {1'b0, buf_cnt};
    assign ReqReady_SO = (credit_used < CREDITS);

    assign RamCSel_SO   = ReqValid_SI && ReqReady_SO;
    assign RamWrEn_SO   = ReqWrEn_SI;
    assign RamAddr_DO   = ReqAddr_DI;
    assign RamWrData_DO = ReqWrData_DI;

    assign rd_accept    = RamCSel_SO && !ReqWrEn_SI;
    assign push         = pend[RAM_LATENCY-1];
    assign RespValid_SO = !buf_empty;
    assign pop          = RespValid_SO && RespReady_SI;
    assign Busy_SO      = (inflight_cnt != '0) || (buf_cnt != '0);

    // pend[k] marks a read whose data appears on RamRdData_DI k+1 edges after accept.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            pend         <= '0;
            inflight_cnt <= '0;
        end else begin
            pend <= (pend << 1) | RAM_LATENCY'(rd_accept);
            if (rd_accept && !push) begin
                inflight_cnt <= inflight_cnt + CNT_W'(1);
            end else if (!rd_accept && push) begin
                inflight_cnt <= inflight_cnt - CNT_W'(1);
            end
        end
    end

    ram_resp_fifo #(
        .DEPTH      (RESP_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .Clk_CI    (Clk_CI),
        .Rst_RBI   (Rst_RBI),
        .push      (push),
        .push_data (RamRdData_DI),
        .pop       (pop),
        .pop_data  (RespData_DO),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_cnt)
    );

    a_no_overflow: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
        push |-> (!buf_full || pop));

endmodule

// File: tb/tb_sync_ram_port_requester.sv
// tb/tb_sync_ram_port_requester.sv - directed bench for both RAM latencies
module tb_sync_ram_port_requester;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wen   [2];
    logic [9:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        resp_valid[2];
    logic        resp_ready[2];
    logic [31:0] resp_data [2];
    logic        ram_csel  [2];
    logic        ram_wen   [2];
    logic [9:0]  ram_addr  [2];
    logic [31:0] ram_wdata [2];
    logic        busy      [2];

    logic [31:0] ram_mem0 [1024];
    logic [31:0] ram_mem1 [1024];
    logic [31:0] rdq0 = '0;
    logic [31:0] rdq1 = '0;
    logic [31:0] rdq1_o = '0;
    logic [31:0] model_mem [2][1024];

    logic [31:0] got_q [$];
    int          pop_q [$];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sync_ram_port_requester #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RAM_LATENCY(1), .RESP_DEPTH(4)) dut0 (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .ReqValid_SI(req_valid[0]), .ReqReady_SO(req_ready[0]), .ReqWrEn_SI(req_wen[0]),
        .ReqAddr_DI(req_addr[0]), .ReqWrData_DI(req_wdata[0]),
        .RespValid_SO(resp_valid[0]), .RespReady_SI(resp_ready[0]), .RespData_DO(resp_data[0]),
        .RamCSel_SO(ram_csel[0]), .RamWrEn_SO(ram_wen[0]), .RamAddr_DO(ram_addr[0]),
        .RamWrData_DO(ram_wdata[0]), .RamRdData_DI(rdq0), .Busy_SO(busy[0]));

    sync_ram_port_requester #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RAM_LATENCY(2), .RESP_DEPTH(4)) dut1 (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .ReqValid_SI(req_valid[1]), .ReqReady_SO(req_ready[1]), .ReqWrEn_SI(req_wen[1]),
        .ReqAddr_DI(req_addr[1]), .ReqWrData_DI(req_wdata[1]),
        .RespValid_SO(resp_valid[1]), .RespReady_SI(resp_ready[1]), .RespData_DO(resp_data[1]),
        .RamCSel_SO(ram_csel[1]), .RamWrEn_SO(ram_wen[1]), .RamAddr_DO(ram_addr[1]),
        .RamWrData_DO(ram_wdata[1]), .RamRdData_DI(rdq1_o), .Busy_SO(busy[1]));

    // Behavioural RAMs: latency 1 (no output reg) and latency 2 (output reg).
    always @(posedge clk) begin
        if (ram_csel[0]) begin
            if (ram_wen[0]) ram_mem0[ram_addr[0]] <= ram_wdata[0];
            else            rdq0 <= ram_mem0[ram_addr[0]];
        end
        if (ram_csel[1]) begin
            if (ram_wen[1]) ram_mem1[ram_addr[1]] <= ram_wdata[1];
            else            rdq1 <= ram_mem1[ram_addr[1]];
        end
        rdq1_o <= rdq1;
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (resp_valid[u] && resp_ready[u]) begin
                got_q.push_back(resp_data[u]);
                pop_q.push_back(cyc);
            end
        end
    end

    task automatic do_req(input int u, input logic we, input logic [9:0] a, input logic [31:0] d,
                          input int tmo, output logic ok, output int acc_c);
        req_valid[u] = 1'b1;
        req_wen[u]   = we;
        req_addr[u]  = a;
        req_wdata[u] = d;
        ok = 1'b0;
        acc_c = 0;
        for (int k = 0; k < tmo && !ok; k++) begin
            @(negedge clk);
            if (req_ready[u]) begin
                ok = 1'b1;
                acc_c = cyc + 1;
                if (we) model_mem[u][a] = d;
                else    exp_q.push_back(model_mem[u][a]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        pop_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            @(negedge clk);
            total++; if (req_ready[u] !== 1'b1) begin bad++; $display("FAIL reset_ready u%0d got=%b exp=1", u, req_ready[u]); end
            total++; if (resp_valid[u] !== 1'b0) begin bad++; $display("FAIL reset_rvalid u%0d got=%b exp=0", u, resp_valid[u]); end
            total++; if (resp_data[u] !== 32'h0) begin bad++; $display("FAIL reset_rdata u%0d got=%h exp=0", u, resp_data[u]); end
            total++; if (busy[u] !== 1'b0) begin bad++; $display("FAIL reset_busy u%0d got=%b exp=0", u, busy[u]); end
        end
    endtask

    task automatic test_write_read();
        logic ok;
        int   c;
        clear_q();
        resp_ready[0] = 1'b1;
        do_req(0, 1'b1, 10'h010, 32'hA5A5_0001, 8, ok, c);
        do_req(0, 1'b0, 10'h010, 32'h0, 8, ok, c);
        req_valid[0] = 1'b0;
        for (int k = 0; k < 10 && got_q.size() < 1; k++) @(posedge clk);
        #1;
        total++;
        if (got_q.size() != 1) begin
            bad++; $display("FAIL wr_rd_count got=%0d exp=1", got_q.size());
        end else begin
            total++; if (got_q[0] !== 32'hA5A5_0001) begin bad++; $display("FAIL wr_rd_data got=%h exp=a5a50001", got_q[0]); end
            total++; if (pop_q[0] != c + 1) begin bad++; $display("FAIL wr_rd_latency got=%0d exp=%0d", pop_q[0], c + 1); end
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        int   c;
        int   first = 0;
        clear_q();
        resp_ready[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_req(1, 1'b0, 10'(i), 32'h0, 1, ok, c);
            if (i == 0) first = c;
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=0 exp=1", i); end
        end
        req_valid[1] = 1'b0;
        for (int k = 0; k < 20 && got_q.size() < 8; k++) @(posedge clk);
        #1;
        total++;
        if (got_q.size() != 8) begin
            bad++; $display("FAIL b2b_count got=%0d exp=8", got_q.size());
        end else begin
            total++; if (pop_q[0] != first + 2) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", pop_q[0], first + 2); end
            for (int i = 0; i < 8; i++) begin
                total++; if (got_q[i] !== (32'hC0DE_0000 + 32'(i))) begin bad++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, got_q[i], 32'hC0DE_0000 + 32'(i)); end
                total++; if (pop_q[i] != pop_q[0] + i) begin bad++; $display("FAIL b2b_rate i=%0d got=%0d exp=%0d", i, pop_q[i], pop_q[0] + i); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        int   c;
        int   accepted = 0;
        clear_q();
        resp_ready[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_req(0, 1'b0, 10'h020 + 10'(i), 32'h0, 6, ok, c);
            if (!ok) break;
            accepted++;
        end
        total++; if (accepted != 4) begin bad++; $display("FAIL bp_accepted got=%0d exp=4", accepted); end
        @(negedge clk);
        total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", req_ready[0]); end
        @(posedge clk); #1;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_ready_popcycle got=%b exp=0", req_ready[0]); end
        @(posedge clk); #1;
        do_req(0, 1'b0, 10'h024, 32'h0, 1, ok, c);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=0 exp=1"); end
        if (!ok) do_req(0, 1'b0, 10'h024, 32'h0, 8, ok, c);
        do_req(0, 1'b0, 10'h025, 32'h0, 8, ok, c);
        req_valid[0] = 1'b0;
        for (int k = 0; k < 30 && got_q.size() < 6; k++) @(posedge clk);
        #1;
        total++;
        if (got_q.size() != 6) begin
            bad++; $display("FAIL bp_count got=%0d exp=6", got_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++; if (got_q[i] !== (32'hC0DE_0020 + 32'(i))) begin bad++; $display("FAIL bp_data i=%0d got=%h exp=%h", i, got_q[i], 32'hC0DE_0020 + 32'(i)); end
            end
        end
    endtask

    task automatic test_interleave(input int u);
        logic ok;
        int   c;
        clear_q();
        resp_ready[u] = 1'b1;
        do_req(u, 1'b1, 10'd5, 32'h0000_1111, 4, ok, c);
        do_req(u, 1'b0, 10'd5, 32'h0, 4, ok, c);
        do_req(u, 1'b1, 10'd5, 32'h0000_2222, 4, ok, c);
        do_req(u, 1'b0, 10'd5, 32'h0, 4, ok, c);
        req_valid[u] = 1'b0;
        for (int k = 0; k < 20 && got_q.size() < 2; k++) @(posedge clk);
        #1;
        total++;
        if (got_q.size() != 2) begin
            bad++; $display("FAIL ilv_count u%0d got=%0d exp=2", u, got_q.size());
        end else begin
            total++; if (got_q[0] !== 32'h0000_1111) begin bad++; $display("FAIL ilv_first u%0d got=%h exp=00001111", u, got_q[0]); end
            total++; if (got_q[1] !== 32'h0000_2222) begin bad++; $display("FAIL ilv_second u%0d got=%h exp=00002222", u, got_q[1]); end
        end
    endtask

    task automatic test_mid_reset();
        logic ok;
        int   c;
        clear_q();
        resp_ready[1] = 1'b0;
        for (int i = 0; i < 3; i++) do_req(1, 1'b0, 10'h030 + 10'(i), 32'h0, 4, ok, c);
        req_valid[1] = 1'b0;
        total++; if (busy[1] !== 1'b1) begin bad++; $display("FAIL mrst_busy_before got=%b exp=1", busy[1]); end
        rst_n = 1'b0;
        #1;
        total++; if (resp_valid[1] !== 1'b0) begin bad++; $display("FAIL mrst_rvalid got=%b exp=0", resp_valid[1]); end
        total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%b exp=0", busy[1]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready[1] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL mrst_stale got=%0d exp=0", got_q.size()); end
        total++; if (req_ready[1] !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%b exp=1", req_ready[1]); end
        total++; if (resp_valid[1] !== 1'b0) begin bad++; $display("FAIL mrst_rvalid_after got=%b exp=0", resp_valid[1]); end
    endtask

    task automatic test_stress(input int u, input int n_txn);
        int   nacc = 0;
        int   viol = 0;
        int   nbad = 0;
        int   cycles = 0;
        logic took = 1'b1;
        clear_q();
        while (nacc < n_txn && cycles < 30000) begin
            if (took || !req_valid[u]) begin
                req_valid[u] = ($urandom_range(0, 3) != 0);
                req_wen[u]   = ($urandom_range(0, 2) == 0);
                req_addr[u]  = 10'($urandom_range(0, 15));
                req_wdata[u] = $urandom;
            end
            resp_ready[u] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ram_csel[u] !== (req_valid[u] && req_ready[u])) viol++;
            if (ram_csel[u] && (ram_addr[u] !== req_addr[u] || ram_wen[u] !== req_wen[u]
                                || ram_wdata[u] !== req_wdata[u])) viol++;
            took = req_valid[u] && req_ready[u];
            if (took) begin
                nacc++;
                if (req_wen[u]) model_mem[u][req_addr[u]] = req_wdata[u];
                else            exp_q.push_back(model_mem[u][req_addr[u]]);
            end
            @(posedge clk); #1;
            cycles++;
        end
        req_valid[u] = 1'b0;
        resp_ready[u] = 1'b1;
        for (int k = 0; k < 100 && (busy[u] || got_q.size() < exp_q.size()); k++) @(posedge clk);
        #1;
        total++; if (nacc != n_txn) begin bad++; $display("FAIL stress_progress u%0d got=%0d exp=%0d", u, nacc, n_txn); end
        total++; if (viol != 0) begin bad++; $display("FAIL stress_ram_drive u%0d violations=%0d exp=0", u, viol); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL stress_count u%0d got=%0d exp=%0d", u, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
            total++; if (nbad != 0) begin bad++; $display("FAIL stress_data u%0d mismatched=%0d exp=0", u, nbad); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem0[i] = 32'hC0DE_0000 + 32'(i);
            ram_mem1[i] = 32'hC0DE_0000 + 32'(i);
            model_mem[0][i] = 32'hC0DE_0000 + 32'(i);
            model_mem[1][i] = 32'hC0DE_0000 + 32'(i);
        end
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_wen[u] = 1'b0; req_addr[u] = '0;
            req_wdata[u] = '0; resp_ready[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        @(posedge clk); #1;
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_interleave(0);
        test_interleave(1);
        test_mid_reset();
        test_stress(0, 10000);
        test_stress(1, 10000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
